// File: rtl/rt_pixel_responder.sv
// Ray-tracer responder core: shades one pixel of a sphere per enable rise using
// a sequential shift-add squarer (21 cycles fixed). Optional RT_DITHER_EN adds 2x2 ordered dither.
module rt_pixel_responder #(
  parameter int         CX          = 320,
  parameter int         CY          = 240,
  parameter logic [19:0] R2         = 20'd14400,
  parameter int         SHADE_SHIFT = 10,
  parameter logic [3:0] BG          = 4'h1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RTC_ENABLE,
  input  logic [9:0] RTX,
  input  logic [8:0] RTY,
  output logic       RTC_READY,
  output logic [3:0] RTC_OUTPUT
);

  typedef enum logic [1:0] {IDLE, SQ_X, SQ_Y, SHADE} state_t;

  state_t      state_q, state_d;
  logic        enable_q;
  logic [19:0] acc_q, acc_d;
  logic [19:0] mcand_q, mcand_d;
  logic [9:0]  mplier_q, mplier_d;
  logic [9:0]  ay_q, ay_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  out_q, out_d;
`ifdef RT_DITHER_EN
  logic [1:0]  pix_q, pix_d;
  logic [1:0]  bias;
`endif

  logic [10:0] dx, dy, ndx, ndy;
  logic [9:0]  ax, ay;
  logic        start;
  logic [19:0] partial, acc_sum;
  logic [20:0] s, shaded;
  logic [3:0]  sat, shade_val;

  assign dx  = {1'b0, RTX} - 11'(CX);
  assign dy  = {2'b0, RTY} - 11'(CY);
  assign ndx = -dx;
  assign ndy = -dy;
  assign ax  = dx[10] ? ndx[9:0] : dx[9:0];
  assign ay  = dy[10] ? ndy[9:0] : dy[9:0];

  assign start   = RTC_ENABLE & ~enable_q & (state_q == IDLE);
  assign partial = mplier_q[0] ? mcand_q : '0;
  assign acc_sum = acc_q + partial;

  always_comb begin
    s = {1'b0, acc_q};
`ifdef RT_DITHER_EN
    case (pix_q)
      2'b00:   bias = 2'd0;
      2'b01:   bias = 2'd2;
      2'b10:   bias = 2'd3;
      default: bias = 2'd1;
    endcase
    s = s + (21'(bias) << (SHADE_SHIFT - 2));
`endif
    shaded    = s >> SHADE_SHIFT;
    sat       = (shaded > 21'd15) ? 4'd15 : shaded[3:0];
    shade_val = 4'd15 - sat;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ay_d     = ay_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
`ifdef RT_DITHER_EN
    pix_d    = pix_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {10'b0, ax};
          mplier_d = ax;
          ay_d     = ay;
          cnt_d    = '0;
`ifdef RT_DITHER_EN
          pix_d    = {RTY[0], RTX[0]};
`endif
          state_d  = SQ_X;
        end
      end
      SQ_X, SQ_Y: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          cnt_d = '0;
          if (state_q == SQ_X) begin
            // Reload the shifter with ay so SQ_Y accumulates onto ax*ax.
            mcand_d  = {10'b0, ay_q};
            mplier_d = ay_q;
            state_d  = SQ_Y;
          end else begin
            state_d = SHADE;
          end
        end
      end
      SHADE: begin
        out_d   = (acc_q < R2) ? shade_val : BG;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ay_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
`ifdef RT_DITHER_EN
      pix_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      enable_q <= RTC_ENABLE;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ay_q     <= ay_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
`ifdef RT_DITHER_EN
      pix_q    <= pix_d;
`endif
    end
  end

  assign RTC_READY  = (state_q == IDLE);
  assign RTC_OUTPUT = out_q;

endmodule

// File: tb/tb_rt_pixel_responder.sv
// Directed bench for rt_pixel_responder: scoreboard of expected intensities,
// latency/handshake checks and reset behaviour.
module tb_rt_pixel_responder;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       RTC_ENABLE = 1'b0;
  logic [9:0] RTX = '0;
  logic [8:0] RTY = '0;
  logic       RTC_READY;
  logic [3:0] RTC_OUTPUT;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];

  rt_pixel_responder #(.CX(320), .CY(240), .R2(20'd14400), .SHADE_SHIFT(10), .BG(4'h1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RTC_ENABLE(RTC_ENABLE), .RTX(RTX), .RTY(RTY),
    .RTC_READY(RTC_READY), .RTC_OUTPUT(RTC_OUTPUT)
  );

  always #5 CLK = ~CLK;

  function automatic int model(int x, int y);
    int d2, s, v, b;
    d2 = (x - 320) * (x - 320) + (y - 240) * (y - 240);
    if (d2 >= 14400) return 1;
    b = 0;
`ifdef RT_DITHER_EN
    case ({y % 2, x % 2})
      2: b = 2;
      4: b = 0;
      default: b = 0;
    endcase
    if ((y % 2) == 0 && (x % 2) == 1) b = 2;
    if ((y % 2) == 1 && (x % 2) == 0) b = 3;
    if ((y % 2) == 1 && (x % 2) == 1) b = 1;
`endif
    s = d2 + b * 256;
    v = s / 1024;
    if (v > 15) v = 15;
    return 15 - v;
  endfunction

  task automatic check(string tag, int obs, int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One request; enable held for 'hold' edges counting E0. abort_at>0 resets mid-op.
  task automatic do_req(string tag, int x, int y, int hold, int abort_at);
    int n;
    @(negedge CLK);
    RTX = 10'(x);
    RTY = 9'(y);
    RTC_ENABLE = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge CLK);
    if (hold <= 1) RTC_ENABLE = 1'b0;
    check({tag, "_ready_low"}, int'(RTC_READY), 0);
    n = 0;
    while (RTC_READY === 1'b0 && n < 100) begin
      if (abort_at > 0 && n == abort_at) break;
      @(negedge CLK);
      n++;
      if (n + 1 >= hold) RTC_ENABLE = 1'b0;
    end
    if (abort_at > 0) begin
      #2 RESET_N = 1'b0;
      #1;
      check({tag, "_abort_ready"}, int'(RTC_READY), 1);
      check({tag, "_abort_out"}, int'(RTC_OUTPUT), 0);
      void'(exp_q.pop_back());
      RTC_ENABLE = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
    end else begin
      check({tag, "_latency"}, n, 21);
      if (exp_q.size() > 0) check({tag, "_out"}, int'(RTC_OUTPUT), exp_q.pop_front());
    end
  endtask

  initial begin
    int lows;
    #2;
    check("reset_ready", int'(RTC_READY), 1);
    check("reset_out", int'(RTC_OUTPUT), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    check("idle_ready", int'(RTC_READY), 1);
    check("idle_out", int'(RTC_OUTPUT), 0);

    do_req("centre", 320, 240, 2, 0);
    do_req("origin", 0, 0, 1, 0);
    do_req("edge_x", 440, 240, 1, 0);
    do_req("inside_x", 439, 240, 1, 0);
    do_req("edge_y", 320, 360, 3, 0);
    do_req("shade", 320, 340, 1, 0);
    do_req("shade_odd", 321, 340, 1, 0);
    do_req("diag", 380, 290, 1, 0);
    do_req("far_y", 0, 511, 1, 0);
    do_req("corner", 639, 479, 1, 0);
    do_req("centre2", 320, 240, 1, 0);

    // Asynchronous reset while idle with a non-zero result held.
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("async_rst_ready", int'(RTC_READY), 1);
    check("async_rst_out", int'(RTC_OUTPUT), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_rst_idle", int'(RTC_READY), 1);

    // Long enable with an extra rise while busy: exactly one computation.
    RTX = 10'd320;
    RTY = 9'd340;
    RTC_ENABLE = 1'b1;
    exp_q.push_back(model(320, 340));
    @(negedge CLK);
    lows = (RTC_READY === 1'b0) ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) RTC_ENABLE = 1'b0;
      if (n == 6) RTC_ENABLE = 1'b1;
      if (n == 30) RTC_ENABLE = 1'b0;
      @(negedge CLK);
      if (RTC_READY === 1'b0) lows++;
    end
    check("held_busy_cycles", lows, 21);
    check("held_out", int'(RTC_OUTPUT), exp_q.pop_front());
    do_req("second_rise", 0, 0, 1, 0);

    // Reset mid-computation, then a fresh request.
    do_req("centre", 320, 240, 2, 0);
    do_req("abort", 320, 240, 2, 10);
    do_req("after_abort", 320, 340, 1, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rt_pixel_responder.md
# rt_pixel_responder

- Responder (core) side of the ray-tracer request handshake.
- Accepts a pixel coordinate when its enable rises, computes a 4-bit intensity for a shaded sphere using a sequential shift-add squarer, and presents the result with a ready flag.
- It sits where the frame-buffer write controller expects a ray-tracing core: the controller raises enable, then writes the output to on-chip memory at the current coordinate once ready returns.

## Interface
Parameters:
- CX, 320: sphere centre X (pixels)
- CY, 240: sphere centre Y (pixels)
- R2, 14400: radius squared (120²), 20-bit
- SHADE_SHIFT, 10: right shift applied to d² for shading
- BG, 4'h1: intensity for pixels outside the sphere

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- RTC_ENABLE  in  1  request strobe; rising edge starts a computation
- RTX  in  10  pixel X, 0..639
- RTY  in  9  pixel Y, 0..479 (full 0..511 must not overflow)
- RTC_READY  out  1  high = idle and RTC_OUTPUT valid for last request
- RTC_OUTPUT  out  4  pixel intensity

## Operation
- Rising-edge detect: a registered copy enable_q is kept; start = RTC_ENABLE & ~enable_q & state==IDLE.
- Level-high enable never retriggers. Rises while busy are ignored, not queued.

State machine: IDLE → SQ_X → SQ_Y → SHADE → IDLE.
- IDLE: RTC_READY=1; on start:
  - latch ax=|RTX−CX| and ay=|RTY−CY| (10-bit unsigned, signed 11-bit subtraction)
  - latch bit0 of RTX and RTY
  - clear the 20-bit accumulator acc
  - RTC_READY←0, go to SQ_X
- SQ_X: 10 iterations, LSB first, shift-add of ax·ax into acc; 4-bit iteration counter.
- SQ_Y: 10 iterations adding ay·ay into acc.
- SHADE, on the single edge in this state:
  - d2 = acc (max 175841, fits 20 bits)
  - if d2 < R2: RTC_OUTPUT ← 15 − min(15, s>>SHADE_SHIFT), where s = d2 (plus dither bias if enabled)
  - else: RTC_OUTPUT ← BG
  - RTC_READY←1, go to IDLE
- The inside/outside test always uses the un-dithered d2. Comparison is strict: d2 = R2 is outside.
- RTC_OUTPUT changes only on the SHADE edge and stays stable through IDLE and during the next computation.

## Timing
- Reset values: RTC_READY=1, RTC_OUTPUT=0, state=IDLE, enable_q=0, acc=0.
- Edge E0 samples a rising enable; RTC_READY is low after E0. SQ_X occupies E1–E10, SQ_Y E11–E20, SHADE E21.
- RTC_READY is high after E21: 21 cycles, fixed and independent of the coordinate.
- RTC_READY must fall within one cycle of the enable rise. This lets the controller's next write slot see it low.
- Enable may drop at any time after E0 without effect.
- If enable is still high at E21: no restart until it falls and rises again.
- Reset asserted mid-computation aborts immediately to reset values. Partial results are discarded.

## Configuration
- Macro RT_DITHER_EN.
- Defined: ordered 2×2 dither. s = d2 + (b << (SHADE_SHIFT−2)), with b indexed by {RTY[0],RTX[0]}:
  - 00→0, 01→2, 10→3, 11→1
  - s is 21-bit so it cannot overflow.
- Undefined: s = d2. No bias logic and no latched coordinate bits.

## Test plan
- Reset: RESET_N=0 mid-idle → RTC_READY=1, RTC_OUTPUT=0 asynchronously; after release, no activity without an enable rise.
- Centre: RTX=320, RTY=240, enable high 2 cycles → READY low at next edge, high exactly 21 cycles after sample, OUTPUT=4'hF.
- Outside and boundary: (0,0) → d2=160000 → OUTPUT=1; (440,240) → d2=14400=R2 → OUTPUT=1.
- Interior shade: (320,340) → d2=10000 → OUTPUT=6. With RT_DITHER_EN, (321,340) → s=10001+512=10513 → OUTPUT=5.
- Handshake robustness: enable held high 30 cycles plus extra rises during busy → exactly one computation (READY low 21 cycles); the next clean rise produces a second result.
- Reset mid-op: assert RESET_N=0 at cycle 10 of (320,240) → READY=1, OUTPUT=0; a following request for (320,340) → OUTPUT=6.
